inst_mem_ctrl: RTL

- Parametrised instruction memory for the single-cycle/pipelined MIPS core; successor to the fixed 256-word combinational instruction ROM.
- Adds a registered fetch pipeline with stall, configurable read latency and a program-load write port.
- Adds a hardware NOP-fill sweep after reset and alignment/range error reporting.
- Sits between the PC/IF stage and the boot loader or testbench program loader.

---
 rtl/inst_mem_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/inst_mem_ctrl.sv
// Instruction memory with post-reset NOP-fill sweep, registered fetch pipeline
// (1 or 2 cycles, stallable), program-load write port and address error reporting.
module inst_mem_ctrl #(
  parameter int unsigned        ADDR_W    = 32,
  parameter int unsigned        DATA_W    = 32,
  parameter int unsigned        DEPTH     = 256,
  parameter int unsigned        READ_LAT  = 1,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter logic [DATA_W-1:0]  NOP_WORD  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_stall,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic              inst_err,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ack
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              ack_q, ack_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [ADDR_W-1:0] f_off, l_off;
  logic              f_bad, l_bad;
  logic [IDX_W-1:0]  f_idx, l_idx;
  logic              launch;

  logic              s1_valid_q, s1_valid_d;
  logic              s1_err_q, s1_err_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;

  // BASE_ADDR is DEPTH*4 aligned, so the offset's low bits equal the address's
  // and any set bit above the index field means out of range (incl. wrap-below).
  assign f_off = fetch_addr - BASE_ADDR;
  assign l_off = load_addr - BASE_ADDR;
  assign f_bad = (f_off[1:0] != 2'b00) || (f_off[ADDR_W-1:IDX_W+2] != '0);
  assign l_bad = (l_off[1:0] != 2'b00) || (l_off[ADDR_W-1:IDX_W+2] != '0);
  assign f_idx = f_off[IDX_W+1:2];
  assign l_idx = l_off[IDX_W+1:2];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = (state_q == ST_CLEAR);
    ack_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = NOP_WORD;
    case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        ack_d = load_we;
        if (load_we && !l_bad) begin
          mem_we    = 1'b1;
          mem_waddr = l_idx;
          mem_wdata = load_data;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  // Array is read combinationally for the launching fetch, so a same-edge load returns the old word.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign launch = (state_q == ST_READY) && fetch_req && !fetch_stall;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_err_d   = s1_err_q;
    s1_data_d  = s1_data_q;
    if (!fetch_stall) begin
      s1_valid_d = launch;
      s1_err_d   = launch && f_bad;
      if (!launch) begin
        s1_data_d = '0;
      end else if (f_bad) begin
        s1_data_d = NOP_WORD;
      end else begin
        s1_data_d = mem_q[f_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_err_q   <= s1_err_d;
      s1_data_q  <= s1_data_d;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic              s2_valid_q, s2_valid_d;
    logic              s2_err_q, s2_err_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;

    always_comb begin
      s2_valid_d = s2_valid_q;
      s2_err_d   = s2_err_q;
      s2_data_d  = s2_data_q;
      if (!fetch_stall) begin
        s2_valid_d = s1_valid_q;
        s2_err_d   = s1_err_q;
        s2_data_d  = s1_data_q;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid_q <= 1'b0;
        s2_err_q   <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s2_valid_d;
        s2_err_q   <= s2_err_d;
        s2_data_q  <= s2_data_d;
      end
    end

    assign inst_valid = s2_valid_q;
    assign inst_err   = s2_err_q;
    assign inst       = s2_data_q;
  end else begin : g_lat1
    assign inst_valid = s1_valid_q;
    assign inst_err   = s1_err_q;
    assign inst       = s1_data_q;
  end

  assign busy     = busy_q;
  assign load_ack = ack_q;

endmodule
